pipe_elastic_stages: RTL and testbench

//  Parametrised elastic pipeline-register chain. Generalises the fixed

---
 rtl/pipe_elastic_stages.sv | 152 +++++++++++++++
 tb/tb_pipe_elastic_stages.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_stages.sv
// Elastic pipeline-register chain with per-stage valid/ready handshake,
// an optional skid register per stage (registered ready) and per-stage flush.
module pipe_elastic_stages #(
    parameter int                WIDTH     = 32,
    parameter int                STAGES    = 4,
    parameter int                SKID      = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [WIDTH-1:0]                  i_data,
    input  logic [STAGES-1:0]                 i_flush,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [WIDTH-1:0]                  o_data,
    output logic [$clog2(2*STAGES+1)-1:0]     o_count
);

    localparam int CW = $clog2(2*STAGES+1);

    logic [STAGES-1:0] mv_r;
    logic [STAGES-1:0] sv_r;
    logic [WIDTH-1:0]  md_r [STAGES];
    logic [WIDTH-1:0]  sd_r [STAGES];
    logic [CW-1:0]     count_r;

    logic [STAGES-1:0] mv_s;
    logic [STAGES-1:0] sv_s;
    logic [WIDTH-1:0]  md_s [STAGES];
    logic [WIDTH-1:0]  sd_s [STAGES];
    logic [CW-1:0]     count_s;

    logic [STAGES-1:0] ready_in_s;
    logic [STAGES-1:0] ready_out_s;
    logic [STAGES-1:0] take_s;
    logic [STAGES-1:0] leave_s;
    logic [STAGES:0]   in_v_s;
    logic [STAGES:0]   ready_ext_s;
    logic [WIDTH-1:0]  in_d_s [STAGES];

    // Without skid, stage k can take a payload unless it and every later stage
    // are full and the sink stalls; written flat so no ready bit depends on another.
    function automatic logic tail_full(input logic [STAGES-1:0] v, input int k);
        logic f;
        f = 1'b1;
        for (int j = 0; j < STAGES; j++) begin
            if (j >= k) begin
                f = f & v[j];
            end else begin
                f = f;
            end
        end
        return f;
    endfunction

    // Per-stage ready toward the producer side.
    always_comb begin
        ready_in_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            if (SKID != 0) begin
                ready_in_s[k] = ~sv_r[k];
            end else begin
                ready_in_s[k] = i_ready | ~tail_full(mv_r, k);
            end
        end
    end

    // Handshake terms: what each stage accepts and what leaves each main register.
    always_comb begin
        ready_ext_s = {i_ready, ready_in_s};
        ready_out_s = ready_ext_s[STAGES:1];
        in_v_s      = {mv_r, i_valid};
        in_d_s[0]   = i_data;
        for (int k = 1; k < STAGES; k++) begin
            in_d_s[k] = md_r[k-1];
        end
        take_s  = in_v_s[STAGES-1:0] & ready_in_s;
        leave_s = mv_r & ready_out_s;
    end

    // Next-state of main/skid registers; flush wins over any load into the stage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            mv_s[k] = mv_r[k];
            sv_s[k] = sv_r[k];
            md_s[k] = md_r[k];
            sd_s[k] = sd_r[k];
            if (mv_r[k] && !leave_s[k]) begin
                if (take_s[k]) begin
                    sv_s[k] = 1'b1;
                    sd_s[k] = in_d_s[k];
                end else begin
                    sv_s[k] = sv_r[k];
                end
            end else if (leave_s[k] && sv_r[k]) begin
                mv_s[k] = 1'b1;
                md_s[k] = sd_r[k];
                sv_s[k] = 1'b0;
            end else begin
                mv_s[k] = take_s[k];
                if (take_s[k]) begin
                    md_s[k] = in_d_s[k];
                end else begin
                    md_s[k] = md_r[k];
                end
            end
            if (i_flush[k]) begin
                mv_s[k] = 1'b0;
                sv_s[k] = 1'b0;
            end else begin
                sv_s[k] = (SKID != 0) ? sv_s[k] : 1'b0;
            end
        end
    end

    // Occupancy after this edge: every in, out and flush is already folded into the next valids.
    always_comb begin
        count_s = {CW{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            count_s = count_s + CW'(mv_s[k]) + CW'(sv_s[k]);
        end
    end

    // Stage registers and occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mv_r    <= {STAGES{1'b0}};
            sv_r    <= {STAGES{1'b0}};
            count_r <= {CW{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                md_r[k] <= RESET_VAL;
                sd_r[k] <= RESET_VAL;
            end
        end else begin
            mv_r    <= mv_s;
            sv_r    <= sv_s;
            count_r <= count_s;
            for (int k = 0; k < STAGES; k++) begin
                md_r[k] <= md_s[k];
                sd_r[k] <= sd_s[k];
            end
        end
    end

    assign o_ready = ready_in_s[0];
    assign o_valid = mv_r[STAGES-1];
    assign o_data  = md_r[STAGES-1];
    assign o_count = count_r;

endmodule

// File: tb/tb_pipe_elastic_stages.sv
// Directed bench: a 4-stage skid chain (table-driven plus streaming/reset
// sequences) and a 2-stage skid-less chain for the combinational ready path.
module tb_pipe_elastic_stages;

    logic clk;
    logic reset;

    logic       a_iv, a_or, a_ov, a_ir;
    logic [7:0] a_id, a_od;
    logic [3:0] a_fl, a_cnt;

    logic       b_iv, b_or, b_ov, b_ir;
    logic [7:0] b_id, b_od;
    logic [1:0] b_fl;
    logic [2:0] b_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] fl;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] ec;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    pipe_elastic_stages #(.WIDTH(8), .STAGES(4), .SKID(1), .RESET_VAL(8'h5A)) dut_a (
        .clk(clk), .reset(reset), .i_valid(a_iv), .o_ready(a_or), .i_data(a_id),
        .i_flush(a_fl), .o_valid(a_ov), .i_ready(a_ir), .o_data(a_od), .o_count(a_cnt)
    );

    pipe_elastic_stages #(.WIDTH(8), .STAGES(2), .SKID(0), .RESET_VAL(8'h00)) dut_b (
        .clk(clk), .reset(reset), .i_valid(b_iv), .o_ready(b_or), .i_data(b_id),
        .i_flush(b_fl), .o_valid(b_ov), .i_ready(b_ir), .o_data(b_od), .o_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [3:0] fl,
                                input logic rdy, input logic ev, input logic [7:0] ed,
                                input logic [3:0] ec, input logic er);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.ec = ec; r.er = er;
        return r;
    endfunction

    initial begin
        // backpressure: A..H = 10..17 fill to capacity, 18 refused, then flush of last stage (A,B)
        tbl.push_back(mk(1'b1, 8'h10, 4'h0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1));
        tbl.push_back(mk(1'b1, 8'h11, 4'h0, 1'b0, 1'b0, 8'h00, 4'd2, 1'b1));
        tbl.push_back(mk(1'b1, 8'h12, 4'h0, 1'b0, 1'b0, 8'h00, 4'd3, 1'b1));
        tbl.push_back(mk(1'b1, 8'h13, 4'h0, 1'b0, 1'b1, 8'h10, 4'd4, 1'b1));
        tbl.push_back(mk(1'b1, 8'h14, 4'h0, 1'b0, 1'b1, 8'h10, 4'd5, 1'b1));
        tbl.push_back(mk(1'b1, 8'h15, 4'h0, 1'b0, 1'b1, 8'h10, 4'd6, 1'b1));
        tbl.push_back(mk(1'b1, 8'h16, 4'h0, 1'b0, 1'b1, 8'h10, 4'd7, 1'b1));
        tbl.push_back(mk(1'b1, 8'h17, 4'h0, 1'b0, 1'b1, 8'h10, 4'd8, 1'b0));
        tbl.push_back(mk(1'b1, 8'h18, 4'h0, 1'b0, 1'b1, 8'h10, 4'd8, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 4'h8, 1'b0, 1'b0, 8'h00, 4'd6, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h12, 4'd6, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h13, 4'd5, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h14, 4'd4, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h15, 4'd3, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h16, 4'd2, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h17, 4'd1, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1));
        // flush of stage 1 while its payload moves on; then flush of stage 0 against a load of AB
        tbl.push_back(mk(1'b1, 8'h11, 4'h0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1));
        tbl.push_back(mk(1'b1, 8'h22, 4'h0, 1'b0, 1'b0, 8'h00, 4'd2, 1'b1));
        tbl.push_back(mk(1'b1, 8'h33, 4'h0, 1'b0, 1'b0, 8'h00, 4'd3, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h2, 1'b0, 1'b1, 8'h11, 4'd2, 1'b1));
        tbl.push_back(mk(1'b1, 8'hAB, 4'h1, 1'b0, 1'b1, 8'h11, 4'd2, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h22, 4'd1, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1));

        reset = 1'b1;
        a_iv = 1'b0; a_id = 8'h00; a_fl = 4'h0; a_ir = 1'b0;
        b_iv = 1'b0; b_id = 8'h00; b_fl = 2'b00; b_ir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", a_ov, 1'b0);
        chk("rst_count", a_cnt, 4'd0);
        chk("rst_data", a_od, 8'h5A);
        chk("rst_b_valid", b_ov, 1'b0);
        reset = 1'b0;
        #1;
        chk("rel_ready", a_or, 1'b1);

        // stream 0..9 with the sink always ready
        a_ir = 1'b1;
        for (int c = 0; c < 14; c++) begin
            logic ev;
            a_iv = (c < 10);
            a_id = 8'(c);
            chk($sformatf("t2_ready_%0d", c), a_or, 1'b1);
            tick;
            ev = (c >= 3) && (c <= 12);
            chk($sformatf("t2_valid_%0d", c), a_ov, ev);
            if (ev) begin
                chk($sformatf("t2_data_%0d", c), a_od, 8'(c - 3));
            end
        end
        a_iv = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            a_iv = tbl[i].v;
            a_id = tbl[i].d;
            a_fl = tbl[i].fl;
            a_ir = tbl[i].rdy;
            tick;
            chk($sformatf("vec%0d_valid", i), a_ov, tbl[i].ev);
            chk($sformatf("vec%0d_count", i), a_cnt, tbl[i].ec);
            chk($sformatf("vec%0d_ready", i), a_or, tbl[i].er);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), a_od, tbl[i].ed);
            end
        end
        a_iv = 1'b0; a_fl = 4'h0; a_ir = 1'b0;

        // skid-less 2-stage chain: ready follows the sink combinationally when full
        b_ir = 1'b0;
        #1;
        chk("t6_empty_ready", b_or, 1'b1);
        b_iv = 1'b1; b_id = 8'h01;
        tick;
        chk("t6_cnt1", b_cnt, 3'd1);
        b_id = 8'h02;
        tick;
        chk("t6_cnt2", b_cnt, 3'd2);
        chk("t6_valid", b_ov, 1'b1);
        chk("t6_data1", b_od, 8'h01);
        b_id = 8'h03;
        #1;
        chk("t6_full_ready", b_or, 1'b0);
        b_ir = 1'b1;
        #1;
        chk("t6_comb_ready", b_or, 1'b1);
        tick;
        chk("t6_cnt_same", b_cnt, 3'd2);
        chk("t6_data2", b_od, 8'h02);
        b_iv = 1'b0;
        tick;
        chk("t6_data3", b_od, 8'h03);
        chk("t6_cnt_dr", b_cnt, 3'd1);
        tick;
        chk("t6_empty", b_ov, 1'b0);
        chk("t6_cnt0", b_cnt, 3'd0);
        b_ir = 1'b0;

        // reset mid-cycle with 3 entries held
        a_ir = 1'b0;
        a_iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_id = 8'(8'h31 + i);
            tick;
        end
        a_iv = 1'b0;
        chk("t1_pre_cnt", a_cnt, 4'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_valid", a_ov, 1'b0);
        chk("t1_count", a_cnt, 4'd0);
        chk("t1_data", a_od, 8'h5A);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t1_ready", a_or, 1'b1);
        tick;
        chk("t1_post_cnt", a_cnt, 4'd0);
        chk("t1_post_valid", a_ov, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
